cat_trace_capture: RTL and testbench
====================================

# cat_trace_capture

Trace-capture block that sits beside the cat controller and reads its 11-bit input vector and 22-bit output vector every cycle. It records every cycle with a non-zero output into a small FIFO and hands records to the test harness over a valid/ready port. It also counts y17 assertions, the payload/error output, and raises an alarm at a threshold. It is the reader end of the controller's output interface, used for trace comparison and activation detection in the locking and trojan benchmarks.

## Interface
- DEPTH, 8: FIFO entries; power of two, 2..64.
- ALARM_TH, 5: y17 count at which `alarm` sets; 1..255.
- clk  in  1  clock; sampling on rising edge, which is mid-cycle for the negedge-updated controller.
- rst  in  1  reset, asynchronous, active-high.
- cap_en  in  1  capture enable; when low, no records are pushed, but counters still run.
- x_in  in  11  controller inputs; bit 0 = x1 … bit 10 = x11.
- y_in  in  22  controller outputs; bit 0 = y1 … bit 21 = y22.
- rec_data  out  REC_W  head record; REC_W = 33, or 49 with timestamp.
- rec_valid  out  1  head record valid.
- rec_ready  in  1  harness accepts the head record.
- fill  out  7  current FIFO occupancy, 0..DEPTH.
- ovf  out  1  sticky overflow flag.
- drop_cnt  out  8  dropped records, saturating at 255.
- pay_cnt  out  8  cycles with y17=1, saturating at 255.
- alarm  out  1  sticky; set when pay_cnt ≥ ALARM_TH.

## Operation
- Record format:
  - [21:0] = y_in.
  - [32:22] = x_in.
  - [48:33] = timestamp, present only with the macro defined.
- Capture condition per rising edge: cap_en && (y_in != 0). When true, a push is requested.
- Pop: occurs on a rising edge with rec_valid && rec_ready. rec_data and rec_valid must be stable while rec_valid=1 and rec_ready=0.
- FIFO: circular buffer with read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH. Occupancy is tracked separately in fill.
- Full, push without pop: the new record is dropped, ovf is set, drop_cnt increments. The FIFO contents are not disturbed.
- Full, push and pop in the same edge: both are performed. Nothing is dropped and fill is unchanged.
- Empty, push: the record is written. rec_valid and rec_data appear on the next cycle.
- Empty, pop request: ignored, since rec_valid=0.
- pay_cnt: increments on every edge where y_in[16]=1, independent of cap_en and of FIFO state. It saturates at 255.
- alarm: sets on the edge where pay_cnt's new value ≥ ALARM_TH. It is cleared only by rst.
- ovf is cleared only by rst.
- Reset values: rec_valid=0, rec_data=0, fill=0, ovf=0, drop_cnt=0, pay_cnt=0, alarm=0, pointers=0, timestamp=0.

## Timing
- Push-to-visible latency: 1 cycle. A record captured at edge N drives rec_valid=1 after edge N when the FIFO was empty.
- Throughput: one push and one pop per cycle.
- fill, ovf, drop_cnt, pay_cnt and alarm update on the same edge as the event that changes them.
- rec_data is registered from FIFO storage. It is never combinationally dependent on x_in or y_in.
- Reset asserted mid-operation clears everything asynchronously, including any pending records.
  - A push requested on the first edge after rst deasserts is accepted normally.

## Configuration
- Macro: CAT_TRACE_TIMESTAMP_EN.
- Defined:
  - A 16-bit free-running cycle counter runs from 0 at reset, incrementing every rising edge and wrapping 65535→0.
  - Its pre-increment value at the capture edge goes into bits [48:33].
  - REC_W = 49.
- Undefined:
  - No counter exists.
  - REC_W = 33.
  - Behaviour is otherwise identical.

## Test plan
- Reset, then y_in=22'h000004 and x_in=11'h400 for one edge with rec_ready=0 → rec_valid=1 on the next cycle, rec_data[32:0]={11'h400,22'h000004}, fill=1.
- y_in=0 for 10 edges with cap_en=1 → no push; fill=0, rec_valid=0.
- rec_ready=0, then DEPTH+3 non-zero captures → fill=8, ovf=1, drop_cnt=3, and the head record equals the first capture.
- FIFO full, rec_ready=1, and capture held for 4 edges → fill stays at 8, drop_cnt unchanged, and records drain in order.
- y17 (y_in=22'h010000) for 5 edges → pay_cnt=5 and alarm=1 after the 5th edge. Four pulses leave alarm=0.
- With CAT_TRACE_TIMESTAMP_EN: capture at edges 3 and 65539 after reset → timestamps 2 and 2 (wrap). Asserting rst mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/cat_trace_capture.sv
// Trace capture beside the cat controller: FIFO of non-zero output cycles,
// y17 payload counter with sticky alarm. Optional macro: CAT_TRACE_TIMESTAMP_EN.
// Ports:
//   clk, rst            clock, async active-high reset
//   cap_en              record push enable (counters always run)
//   x_in[10:0]          controller inputs
//   y_in[21:0]          controller outputs
//   rec_data/valid/ready  head record handshake (REC_W = 33 or 49)
//   fill[6:0]           FIFO occupancy
//   ovf, drop_cnt       sticky overflow, saturating drop count
//   pay_cnt, alarm      saturating y17 count, sticky alarm
module cat_trace_capture #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned ALARM_TH = 5,
`ifdef CAT_TRACE_TIMESTAMP_EN
  localparam int unsigned REC_W   = 49
`else
  localparam int unsigned REC_W   = 33
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic [10:0]      x_in,
  input  logic [21:0]      y_in,
  output logic [REC_W-1:0] rec_data,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [6:0]       fill,
  output logic             ovf,
  output logic [7:0]       drop_cnt,
  output logic [7:0]       pay_cnt,
  output logic             alarm
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [6:0]       fill_q, fill_d;
  logic [REC_W-1:0] rec_q, rec_d;
  logic             vld_q;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_q, drop_d;
  logic [7:0]       pay_q, pay_d;
  logic             alarm_q, alarm_d;
  logic [REC_W-1:0] rec_new;
  logic             push_req, pop, full, push_ok;

`ifdef CAT_TRACE_TIMESTAMP_EN
  logic [15:0] ts_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ts_q <= '0;
    else     ts_q <= ts_q + 16'd1;
  end

  assign rec_new = {ts_q, x_in, y_in};
`else
  assign rec_new = {x_in, y_in};
`endif

  assign push_req = cap_en && (y_in != '0);
  assign pop      = vld_q && rec_ready;
  assign full     = (fill_q == 7'(DEPTH));
  // When full, a same-edge pop frees the slot the push lands in.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    rd_d    = rd_q + AW'(pop);
    wr_d    = wr_q + AW'(push_ok);
    fill_d  = fill_q + {6'd0, push_ok} - {6'd0, pop};
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    pay_d   = pay_q;
    rec_d   = rec_q;
    if (push_req && full && !pop) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    if (y_in[16] && pay_q != 8'hFF) pay_d = pay_q + 8'd1;
    alarm_d = alarm_q || (pay_d >= 8'(ALARM_TH));
    // Next head comes from storage, or from the record being written
    // when that record lands in the head slot.
    if (fill_d != '0) begin
      if (push_ok && rd_d == wr_q) rec_d = rec_new;
      else                         rec_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= rec_new;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      fill_q  <= '0;
      rec_q   <= '0;
      vld_q   <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      pay_q   <= '0;
      alarm_q <= 1'b0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      fill_q  <= fill_d;
      rec_q   <= rec_d;
      vld_q   <= (fill_d != '0);
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      pay_q   <= pay_d;
      alarm_q <= alarm_d;
    end
  end

  assign rec_data  = rec_q;
  assign rec_valid = vld_q;
  assign fill      = fill_q;
  assign ovf       = ovf_q;
  assign drop_cnt  = drop_q;
  assign pay_cnt   = pay_q;
  assign alarm     = alarm_q;

endmodule

// File: tb/tb_cat_trace_capture.sv
// Directed bench for cat_trace_capture.
// Covers FIFO fill/overflow/drain, y17 alarm, async reset, timestamps.
module tb_cat_trace_capture;

`ifdef CAT_TRACE_TIMESTAMP_EN
  localparam int RW = 49;
`else
  localparam int RW = 33;
`endif
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cap_en = 1'b0;
  logic [10:0]   x_in = '0;
  logic [21:0]   y_in = '0;
  logic [RW-1:0] rec_data;
  logic          rec_valid;
  logic          rec_ready = 1'b0;
  logic [6:0]    fill;
  logic          ovf;
  logic [7:0]    drop_cnt;
  logic [7:0]    pay_cnt;
  logic          alarm;

  int n_chk  = 0;
  int n_pass = 0;
  int q[$];

  always #5 clk = ~clk;

  cat_trace_capture #(.DEPTH(DEPTH), .ALARM_TH(5)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en),
    .x_in(x_in), .y_in(y_in),
    .rec_data(rec_data), .rec_valid(rec_valid), .rec_ready(rec_ready),
    .fill(fill), .ovf(ovf), .drop_cnt(drop_cnt),
    .pay_cnt(pay_cnt), .alarm(alarm)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(rec_valid), 64'd0);
    chk({tag, "_data"},  64'(rec_data),  64'd0);
    chk({tag, "_fill"},  64'(fill),      64'd0);
    chk({tag, "_ovf"},   64'(ovf),       64'd0);
    chk({tag, "_drop"},  64'(drop_cnt),  64'd0);
    chk({tag, "_pay"},   64'(pay_cnt),   64'd0);
    chk({tag, "_alarm"}, 64'(alarm),     64'd0);
  endtask

  initial begin
    #12;
    chk_zero("rst");
    rst = 1'b0;
    tick();

    // Single capture into empty FIFO
    cap_en = 1'b1; x_in = 11'h400; y_in = 22'h000004;
    tick();
    y_in = '0; x_in = '0;
    chk("one_valid", 64'(rec_valid), 64'd1);
    chk("one_data", 64'(rec_data[32:0]), 64'({11'h400, 22'h000004}));
    chk("one_fill", 64'(fill), 64'd1);
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
    chk("pop_fill", 64'(fill), 64'd0);
    chk("pop_valid", 64'(rec_valid), 64'd0);

    // Zero outputs are not captured
    repeat (10) tick();
    chk("zero_fill", 64'(fill), 64'd0);
    chk("zero_valid", 64'(rec_valid), 64'd0);

    // Overflow: DEPTH+3 captures, no pops
    for (int i = 0; i < DEPTH + 3; i++) begin
      x_in = 11'(i); y_in = 22'(i + 1);
      tick();
    end
    y_in = '0; x_in = '0;
    chk("ovf_fill", 64'(fill), 64'd8);
    chk("ovf_flag", 64'(ovf), 64'd1);
    chk("ovf_drop", 64'(drop_cnt), 64'd3);
    chk("ovf_head", 64'(rec_data[32:0]), 64'({11'd0, 22'd1}));
    tick();
    chk("hold_head", 64'(rec_data[32:0]), 64'({11'd0, 22'd1}));
    chk("hold_valid", 64'(rec_valid), 64'd1);

    // Full with push and pop each edge
    for (int i = 1; i <= DEPTH; i++) q.push_back(i);
    rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      y_in = 22'(100 + i);
      tick();
      void'(q.pop_front());
      q.push_back(100 + i);
      chk("pp_fill", 64'(fill), 64'd8);
      chk("pp_drop", 64'(drop_cnt), 64'd3);
      chk("pp_head", 64'(rec_data[21:0]), 64'(q[0]));
    end
    y_in = '0;
    while (q.size() > 0) begin
      chk("drain_valid", 64'(rec_valid), 64'd1);
      chk("drain_head", 64'(rec_data[21:0]), 64'(q[0]));
      tick();
      void'(q.pop_front());
    end
    rec_ready = 1'b0;
    chk("drain_fill", 64'(fill), 64'd0);
    chk("drain_valid_end", 64'(rec_valid), 64'd0);

    // y17 payload counter and alarm threshold
    cap_en = 1'b0; y_in = 22'h010000;
    repeat (4) tick();
    chk("pay4", 64'(pay_cnt), 64'd4);
    chk("alarm4", 64'(alarm), 64'd0);
    tick();
    chk("pay5", 64'(pay_cnt), 64'd5);
    chk("alarm5", 64'(alarm), 64'd1);
    chk("pay_nocap", 64'(fill), 64'd0);
    repeat (260) tick();
    chk("pay_sat", 64'(pay_cnt), 64'd255);
    y_in = '0;
    tick();
    chk("alarm_sticky", 64'(alarm), 64'd1);

    // Async reset mid-stream
    cap_en = 1'b1; y_in = 22'd7;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    chk_zero("arst");
    #1 rst = 1'b0;
    y_in = 22'd9;
    tick();
    y_in = '0;
    chk("post_rst_valid", 64'(rec_valid), 64'd1);
    chk("post_rst_fill", 64'(fill), 64'd1);
    chk("post_rst_data", 64'(rec_data[21:0]), 64'd9);

`ifdef CAT_TRACE_TIMESTAMP_EN
    rst = 1'b1;
    #1 rst = 1'b0;
    rec_ready = 1'b1;
    for (int e = 1; e <= 65539; e++) begin
      y_in = (e == 3 || e == 65539) ? 22'd5 : 22'd0;
      tick();
      if (e == 3 || e == 65539) begin
        chk("ts_valid", 64'(rec_valid), 64'd1);
        chk("ts_val", 64'(rec_data[48:33]), 64'd2);
      end
    end
    y_in = '0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
